// File: rtl/maze_pkg.sv
// Shared types for the maze path finder: controller states and
// move-priority encodings.
package maze_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRUNE,
        WALK,
        FAIL
    } state_t;

    // Value of pri_right selecting which move is tried first.
    localparam logic PRI_DOWN  = 1'b0;
    localparam logic PRI_RIGHT = 1'b1;

endpackage : maze_pkg

// File: rtl/maze_prune_step.sv
// One parallel pruning step over the whole keep map. A cell survives only if
// it is open and is either the goal or has a surviving down or right
// neighbour. Cells outside the grid count as blocked. Purely combinational;
// the caller holds the keep map in its own registers.
module maze_prune_step #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic [ROWS-1:0][COLS-1:0] keep_i,
    output logic [ROWS-1:0][COLS-1:0] keep_o,
    output logic                      stable_o
);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam logic IS_GOAL = (r == ROWS - 1) && (c == COLS - 1);
            logic down_ok;
            logic right_ok;

            if (r < ROWS - 1) begin : g_down
                assign down_ok = keep_i[r+1][c];
            end else begin : g_no_down
                assign down_ok = 1'b0;
            end

            if (c < COLS - 1) begin : g_right
                assign right_ok = keep_i[r][c+1];
            end else begin : g_no_right
                assign right_ok = 1'b0;
            end

            assign keep_o[r][c] = keep_i[r][c] & (IS_GOAL | down_ok | right_ok);
        end
    end

    // Nothing would change this step: the keep map has reached its fixed point.
    assign stable_o = (keep_o == keep_i);

endmodule : maze_prune_step

// File: rtl/maze_path_finder.sv
// Down/right maze solver. Loads a ROWS x COLS grid one row per cycle, prunes
// cells that cannot reach the bottom-right goal until the map is stable, then
// streams the path from (0,0) to the goal one coordinate per cycle, or emits a
// single fail beat when no path exists. The grid register doubles as the keep
// map once loading is finished.
module maze_path_finder
    import maze_pkg::*;
#(
    parameter  int ROWS = 8,
    parameter  int COLS = 8,
    localparam int RW   = $clog2(ROWS),
    localparam int CW   = $clog2(COLS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [COLS-1:0] maze,
    input  logic            pri_right,
    output logic            busy,
    output logic            out_valid,
    output logic            out_fail,
    output logic [RW-1:0]   out_row,
    output logic [CW-1:0]   out_col
);

    localparam logic [RW-1:0] LAST_R = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_C = CW'(COLS - 1);
    localparam logic [RW-1:0] R_ONE  = RW'(1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    state_t                    state_q, state_d;
    logic [ROWS-1:0][COLS-1:0] grid_q, grid_d;
    logic [RW-1:0]             row_q, row_d;
    logic                      pri_q, pri_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_fail_q, out_fail_d;
    logic [RW-1:0]             pos_r_q, pos_r_d;
    logic [CW-1:0]             pos_c_q, pos_c_d;

    logic [ROWS-1:0][COLS-1:0] keep_nxt;
    logic                      stable;
    logic                      at_goal;
    logic                      down_ok;
    logic                      right_ok;

    maze_prune_step #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_prune_step (
        .keep_i   (grid_q),
        .keep_o   (keep_nxt),
        .stable_o (stable)
    );

    // Neighbour survival around the current walk position; the keep map
    // guarantees at least one of them holds whenever we are not at the goal.
    always_comb begin
        at_goal  = (pos_r_q == LAST_R) && (pos_c_q == LAST_C);
        down_ok  = 1'b0;
        right_ok = 1'b0;
        if (pos_r_q != LAST_R) begin
            down_ok = grid_q[pos_r_q + R_ONE][pos_c_q];
        end
        if (pos_c_q != LAST_C) begin
            right_ok = grid_q[pos_r_q][pos_c_q + C_ONE];
        end
    end

    // Next-state and registered-output decode; outputs are prepared one cycle
    // ahead so every beat comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        grid_d      = grid_q;
        row_d       = row_q;
        pri_d       = pri_q;
        out_valid_d = 1'b0;
        out_fail_d  = 1'b0;
        pos_r_d     = '0;
        pos_c_d     = '0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    grid_d[0] = maze;
                    row_d     = R_ONE;
                    pri_d     = pri_right;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    grid_d[row_q] = maze;
                    row_d         = row_q + R_ONE;
                    if (row_q == LAST_R) begin
                        row_d   = '0;
                        state_d = PRUNE;
                    end
                end
            end
            PRUNE: begin
                grid_d = keep_nxt;
                if (stable) begin
                    out_valid_d = 1'b1;
                    if (grid_q[0][0]) begin
                        state_d = WALK;
                    end else begin
                        out_fail_d = 1'b1;
                        state_d    = FAIL;
                    end
                end
            end
            WALK: begin
                if (at_goal) begin
                    state_d = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                    pos_r_d     = pos_r_q;
                    pos_c_d     = pos_c_q;
                    if (pri_q == PRI_RIGHT) begin
                        if (right_ok) pos_c_d = pos_c_q + C_ONE;
                        else          pos_r_d = pos_r_q + R_ONE;
                    end else begin
                        if (down_ok)  pos_r_d = pos_r_q + R_ONE;
                        else          pos_c_d = pos_c_q + C_ONE;
                    end
                end
            end
            FAIL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Grid/keep map, load bookkeeping and output registers; reset clears the
    // grid and kills any beat in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grid_q      <= '0;
            row_q       <= '0;
            pri_q       <= PRI_DOWN;
            out_valid_q <= 1'b0;
            out_fail_q  <= 1'b0;
            pos_r_q     <= '0;
            pos_c_q     <= '0;
        end else begin
            grid_q      <= grid_d;
            row_q       <= row_d;
            pri_q       <= pri_d;
            out_valid_q <= out_valid_d;
            out_fail_q  <= out_fail_d;
            pos_r_q     <= pos_r_d;
            pos_c_q     <= pos_c_d;
        end
    end

    // A job is in progress from its first row beat until the controller is
    // back in IDLE, which is the cycle after the last output beat.
    assign busy      = (state_q != IDLE) | in_valid;
    assign out_valid = out_valid_q;
    assign out_fail  = out_fail_q;
    assign out_row   = pos_r_q;
    assign out_col   = pos_c_q;

endmodule : maze_path_finder

// File: tb/tb_maze_path_finder.sv
// Bench for maze_path_finder: an 8x8 instance and a 4x6 instance share one
// clock. Expected paths come from a reachability table filled by a single
// backward sweep from the goal, followed by a walk using the priority rule.
module tb_maze_path_finder;

    logic clk;
    logic rst_n;

    logic       iv_a, pr_a;
    logic [7:0] mz_a;
    logic       busy_a, ov_a, of_a;
    logic [2:0] row_a, col_a;

    logic       iv_b, pr_b;
    logic [5:0] mz_b;
    logic       busy_b, ov_b, of_b;
    logic [1:0] row_b;
    logic [2:0] col_b;

    maze_path_finder #(.ROWS(8), .COLS(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .maze(mz_a), .pri_right(pr_a),
        .busy(busy_a), .out_valid(ov_a), .out_fail(of_a), .out_row(row_a), .out_col(col_a)
    );

    maze_path_finder #(.ROWS(4), .COLS(6)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .maze(mz_b), .pri_right(pr_b),
        .busy(busy_b), .out_valid(ov_b), .out_fail(of_b), .out_row(row_b), .out_col(col_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int sel;                   // 0 = 8x8 instance, 1 = 4x6 instance
    logic        obs_valid;
    logic        obs_busy;
    logic [31:0] obs_beat;     // fail*256 + row*16 + col

    always_comb begin
        obs_valid = ov_a;
        obs_busy  = busy_a;
        obs_beat  = {23'd0, of_a, 1'b0, row_a, 1'b0, col_a};
        if (sel == 1) begin
            obs_valid = ov_b;
            obs_busy  = busy_b;
            obs_beat  = {23'd0, of_b, 2'b00, row_b, 1'b0, col_b};
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference model state
    logic [15:0] mz [16];
    int          exp_q[$];
    bit          exp_fail;

    task automatic build_expected(input int rows, input int cols, input logic pri);
        bit reach [16][16];
        int r, c;
        bit dn, rt;
        for (int i = rows - 1; i >= 0; i--) begin
            for (int j = cols - 1; j >= 0; j--) begin
                if (i == rows - 1 && j == cols - 1) reach[i][j] = mz[i][j];
                else reach[i][j] = mz[i][j] &&
                                   ((i + 1 < rows && reach[i+1][j]) || (j + 1 < cols && reach[i][j+1]));
            end
        end
        exp_q.delete();
        exp_fail = !reach[0][0];
        if (!exp_fail) begin
            r = 0; c = 0;
            exp_q.push_back(0);
            while (!(r == rows - 1 && c == cols - 1)) begin
                dn = (r + 1 < rows) && reach[r+1][c];
                rt = (c + 1 < cols) && reach[r][c+1];
                if (pri) begin
                    if (rt) c++; else r++;
                end else begin
                    if (dn) r++; else c++;
                end
                exp_q.push_back(r * 16 + c);
            end
        end
    endtask

    // Load mz[] into the selected instance, then check every output beat.
    task automatic run_job(input int sel_i, input logic pri, input bit inject,
                           input int rst_beat, output int lat, output int nbeats);
        int rows, cols, n_exp;
        bit seen;
        logic [31:0] e;
        rows = (sel_i == 1) ? 4 : 8;
        cols = (sel_i == 1) ? 6 : 8;
        build_expected(rows, cols, pri);
        n_exp = exp_fail ? 1 : exp_q.size();
        sel = sel_i;
        @(posedge clk); #1;
        for (int r = 0; r < rows; r++) begin
            if (sel_i == 1) begin iv_b = 1'b1; mz_b = mz[r][5:0]; pr_b = pri; end
            else            begin iv_a = 1'b1; mz_a = mz[r][7:0]; pr_a = pri; end
            @(posedge clk); #1;
        end
        iv_a = 1'b0; iv_b = 1'b0;
        if (inject) begin
            if (sel_i == 1) begin iv_b = 1'b1; mz_b = 6'($urandom); end
            else            begin iv_a = 1'b1; mz_a = 8'($urandom); end
            fork
                begin
                    @(posedge clk); #1;
                    iv_a = 1'b0; iv_b = 1'b0;
                end
            join_none
        end
        lat = 0; seen = 0; nbeats = 0;
        while (lat < 400 && !seen) begin
            @(negedge clk);
            lat++;
            seen = (obs_valid === 1'b1);
        end
        chk("first_beat_seen", {31'd0, seen}, 32'd1);
        if (!seen) return;
        while (obs_valid === 1'b1 && nbeats < 40) begin
            if (exp_fail) e = (nbeats == 0) ? 32'd256 : 32'hFFFF_FFFF;
            else e = (nbeats < exp_q.size()) ? exp_q[nbeats] : 32'hFFFF_FFFF;
            chk($sformatf("beat%0d", nbeats), obs_beat, e);
            chk("busy_in_beat", {31'd0, obs_busy}, 32'd1);
            nbeats++;
            if (nbeats == rst_beat) begin
                #1 rst_n = 1'b0;
                #1;
                chk("rst_out_valid", {31'd0, obs_valid}, 32'd0);
                chk("rst_busy", {31'd0, obs_busy}, 32'd0);
                chk("rst_coords", obs_beat, 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
        end
        chk("beat_count", nbeats, n_exp);
        chk("busy_after", {31'd0, obs_busy}, 32'd0);
        chk("idle_outputs", obs_beat, 32'd0);
    endtask

    task automatic quiet_cycles(input string tag, input int n);
        int hits;
        hits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (obs_valid !== 1'b0 || obs_busy !== 1'b0) hits++;
        end
        chk(tag, hits, 0);
    endtask

    initial begin
        int lat, nb;
        sel = 0;
        rst_n = 1'b0;
        iv_a = 1'b0; mz_a = '0; pr_a = 1'b0;
        iv_b = 1'b0; mz_b = '0; pr_b = 1'b0;
        for (int i = 0; i < 16; i++) mz[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_valid_a", {31'd0, ov_a}, 32'd0);
        chk("reset_busy_a", {31'd0, busy_a}, 32'd0);
        chk("reset_beat_a", {23'd0, of_a, 1'b0, row_a, 1'b0, col_a}, 32'd0);
        chk("reset_valid_b", {31'd0, ov_b}, 32'd0);
        chk("reset_beat_b", {23'd0, of_b, 2'b00, row_b, 1'b0, col_b}, 32'd0);
        rst_n = 1'b1;

        // 8x8 all open, prefer down: stable grid, first beat 2 cycles later
        for (int i = 0; i < 8; i++) mz[i] = 16'h00FF;
        run_job(0, 1'b0, 1'b0, -1, lat, nb);
        chk("open_down_latency", lat, 2);
        chk("open_down_beats", nb, 15);

        // 8x8 all open, prefer right
        run_job(0, 1'b1, 1'b0, -1, lat, nb);
        chk("open_right_latency", lat, 2);

        // Dead-end spur: four prune steps (three removals then a stable one)
        mz[0] = 16'h07; mz[1] = 16'h05;
        for (int i = 2; i < 7; i++) mz[i] = 16'h01;
        mz[7] = 16'hFF;
        run_job(0, 1'b1, 1'b0, -1, lat, nb);
        chk("spur_latency", lat, 5);

        // Goal blocked
        for (int i = 0; i < 7; i++) mz[i] = 16'hFF;
        mz[7] = 16'h7F;
        run_job(0, 1'b0, 1'b0, -1, lat, nb);
        chk("goal_blocked_beats", nb, 1);

        // Wall across row 3
        for (int i = 0; i < 8; i++) mz[i] = 16'hFF;
        mz[3] = 16'h00;
        run_job(0, 1'b1, 1'b0, -1, lat, nb);
        chk("wall_beats", nb, 1);

        // 4x6, only (3,0) blocked, prefer down
        for (int i = 0; i < 4; i++) mz[i] = 16'h3F;
        mz[3] = 16'h3E;
        run_job(1, 1'b0, 1'b0, -1, lat, nb);
        chk("b_latency", lat, 2);
        chk("b_beats", nb, 9);

        // Randomised grids on both instances
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) mz[i] = 16'($urandom | $urandom);
            if (k % 3 != 0) begin
                mz[0][0] = 1'b1;
                if (k % 2 == 0) mz[7][7] = 1'b1;
                else            mz[3][5] = 1'b1;
            end
            run_job(k % 2, 1'($urandom), 1'b0, -1, lat, nb);
        end

        // Reset during the fifth walk beat, then a clean job with a stray
        // in_valid pulse while pruning
        for (int i = 0; i < 8; i++) mz[i] = 16'hFF;
        run_job(0, 1'b0, 1'b0, 5, lat, nb);
        sel = 0;
        quiet_cycles("quiet_after_reset", 6);
        mz[0] = 16'h07; mz[1] = 16'h05;
        for (int i = 2; i < 7; i++) mz[i] = 16'h01;
        mz[7] = 16'hFF;
        run_job(0, 1'b0, 1'b1, -1, lat, nb);
        chk("inject_latency", lat, 5);
        quiet_cycles("quiet_after_inject", 6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_maze_path_finder
